// File: rtl/mem_arbiter_pkg.sv
// Shared widths, FSM encodings and requester IDs for the memory arbiter.
// No logic; pure types and constants.
// No flow control.
package mem_arbiter_pkg;

    localparam int XLEN = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } arb_state_t;

    typedef enum logic {
        REQ_IF = 1'b0,
        REQ_LS = 1'b1
    } req_id_t;

    localparam logic [7:0] IF_WMASK = 8'h0F;

endpackage

// File: rtl/mem_arbiter_arb_grant.sv
// One-hot grant between fetch and load-store requesters; ptr is the last winner.
// Latency: combinational, no state.
// Backpressure: none; the caller gates the grant with its own FSM state.
module arb_grant
    import mem_arbiter_pkg::*;
(
    input  logic       if_valid,
    input  logic       ls_valid,
    input  req_id_t    ptr,
    output logic [1:0] grant
);

    logic ls_wins;

    // On contention the requester that did not win last time is preferred.
    assign ls_wins  = (ptr == REQ_IF);
    assign grant[0] = if_valid & (~ls_valid | ~ls_wins);
    assign grant[1] = ls_valid & (~if_valid | ls_wins);

endmodule

// File: rtl/mem_arbiter.sv
// Single-outstanding arbiter of IF and LSU onto one memory port; MEM_ARB_RR_EN selects round-robin.
// Latency: accept -> mem_req next cycle; response pulse one cycle after mem_resp_valid.
// Backpressure: both req_ready low while a transaction is in flight; mem_req held until mem_req_ready.
module mem_arbiter #(
    parameter int XLEN      = mem_arbiter_pkg::XLEN,
    parameter bit RST_GRANT = 1'b0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            if_req_valid,
    output logic            if_req_ready,
    input  logic [XLEN-1:0] if_req_addr,
    output logic            if_resp_valid,
    output logic [XLEN-1:0] if_resp_data,
    input  logic            ls_req_valid,
    output logic            ls_req_ready,
    input  logic [XLEN-1:0] ls_req_addr,
    input  logic            ls_req_wen,
    input  logic [XLEN-1:0] ls_req_wdata,
    input  logic [7:0]      ls_req_wmask,
    output logic            ls_resp_valid,
    output logic [XLEN-1:0] ls_resp_data,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_req_addr,
    output logic            mem_req_wen,
    output logic [XLEN-1:0] mem_req_wdata,
    output logic [7:0]      mem_req_wmask,
    input  logic            mem_resp_valid,
    input  logic [XLEN-1:0] mem_resp_data
);
    import mem_arbiter_pkg::*;

    arb_state_t      state, state_nxt;
    req_id_t         owner, ptr;
    logic [1:0]      grant;
    logic            if_acc, ls_acc;
    logic            if_resp_q, ls_resp_q;
    logic [XLEN-1:0] resp_data;

`ifdef MEM_ARB_RR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      ptr <= req_id_t'(RST_GRANT);
        else if (ls_acc) ptr <= REQ_LS;
        else if (if_acc) ptr <= REQ_IF;
    end
`else
    // Pretending IF won last time makes the grant logic give LSU fixed priority.
    assign ptr = REQ_IF;
    logic unused_rst_grant;
    assign unused_rst_grant = RST_GRANT;
`endif

    arb_grant u_arb_grant (
        .if_valid (if_req_valid),
        .ls_valid (ls_req_valid),
        .ptr      (ptr),
        .grant    (grant)
    );

    assign if_req_ready  = (state == IDLE) & grant[0];
    assign ls_req_ready  = (state == IDLE) & grant[1];
    assign if_acc        = if_req_valid & if_req_ready;
    assign ls_acc        = ls_req_valid & ls_req_ready;
    assign mem_req_valid = (state == REQ);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (if_acc || ls_acc) state_nxt = REQ;
            REQ:     if (mem_req_ready)    state_nxt = WAIT;
            WAIT:    if (mem_resp_valid)   state_nxt = IDLE;
            default:                       state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_req_addr  <= '0;
            mem_req_wen   <= 1'b0;
            mem_req_wdata <= '0;
            mem_req_wmask <= '0;
            owner         <= REQ_IF;
        end else if (ls_acc) begin
            mem_req_addr  <= ls_req_addr;
            mem_req_wen   <= ls_req_wen;
            mem_req_wdata <= ls_req_wdata;
            mem_req_wmask <= ls_req_wmask;
            owner         <= REQ_LS;
        end else if (if_acc) begin
            mem_req_addr  <= if_req_addr;
            mem_req_wen   <= 1'b0;
            mem_req_wdata <= '0;
            mem_req_wmask <= IF_WMASK;
            owner         <= REQ_IF;
        end
    end

    // Responses outside WAIT are stale (e.g. after a reset abort) and are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_resp_q <= 1'b0;
            ls_resp_q <= 1'b0;
            resp_data <= '0;
        end else begin
            if_resp_q <= 1'b0;
            ls_resp_q <= 1'b0;
            if ((state == WAIT) && mem_resp_valid) begin
                resp_data <= mem_resp_data;
                if_resp_q <= (owner == REQ_IF);
                ls_resp_q <= (owner == REQ_LS);
            end
        end
    end

    assign if_resp_valid = if_resp_q;
    assign ls_resp_valid = ls_resp_q;
    assign if_resp_data  = resp_data;
    assign ls_resp_data  = resp_data;

endmodule
